// File: rtl/ball_controller.sv
// ball_controller: ball motion, paddle collision and scoring engine.
// Updates happen once per movement tick derived from the pixel clock.
module ball_controller #(
   parameter int SCREEN_WIDTH            = 640,
   parameter int SCREEN_HEIGHT           = 480,
   parameter int BALL_RADIUS             = 8,
   parameter int PLAYER_RADIUS           = 35,
   parameter int TEAM1_HOR_POS           = 40,
   parameter int TEAM2_HOR_POS           = 600,
   parameter int INITIAL_X               = 320,
   parameter int INITIAL_Y               = 240,
   parameter int BALL_MOVEMENT_FREQUENCY = 100000,
   parameter int SERVE_DELAY             = 64,
   parameter int WIN_SCORE               = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] team1_ver_position,
   input  logic [9:0] team2_ver_position,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] team1_score,
   output logic [3:0] team2_score,
   output logic       goal_pulse,
   output logic       game_over
);

   localparam int TICK_W  = (BALL_MOVEMENT_FREQUENCY > 1) ? $clog2(BALL_MOVEMENT_FREQUENCY) : 1;
   localparam int SERVE_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(BALL_MOVEMENT_FREQUENCY - 1);
   localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_DELAY - 1);
   localparam logic [9:0]  INIT_X  = 10'(INITIAL_X);
   localparam logic [9:0]  INIT_Y  = 10'(INITIAL_Y);
   localparam logic [9:0]  X_HIT1  = 10'(TEAM1_HOR_POS + 1 + BALL_RADIUS);
   localparam logic [9:0]  X_HIT2  = 10'(TEAM2_HOR_POS - 1 - BALL_RADIUS);
   localparam logic [9:0]  X_MIN   = 10'(BALL_RADIUS);
   localparam logic [9:0]  X_MAX   = 10'(SCREEN_WIDTH - 1 - BALL_RADIUS);
   localparam logic [9:0]  Y_MIN   = 10'(BALL_RADIUS);
   localparam logic [10:0] R11     = 11'(BALL_RADIUS);
   localparam logic [10:0] H11     = 11'(SCREEN_HEIGHT - 1);
   localparam logic [10:0] PR11    = 11'(PLAYER_RADIUS);
   localparam logic [3:0]  WIN_M1  = 4'(WIN_SCORE - 1);

   typedef enum logic [1:0] {
      SERVE,
      PLAY,
      OVER
   } state_t;

   state_t              state;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick;
   logic [SERVE_W-1:0]  serve_cnt;
   logic                dx_pos;
   logic                dy_pos;
   logic signed [10:0]  diff1;
   logic signed [10:0]  diff2;
   logic [10:0]         dist1;
   logic [10:0]         dist2;
   logic                hit1;
   logic                hit2;
   logic                goal1;
   logic                goal2;
   logic                at_bottom;
   logic                at_top;

   assign tick = (tick_cnt == TICK_LAST);

   // Free-running movement tick divider, active in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   // Collision, wall and goal detection from the current ball position.
   always_comb begin
      diff1     = $signed({1'b0, ball_y}) - $signed({1'b0, team1_ver_position});
      diff2     = $signed({1'b0, ball_y}) - $signed({1'b0, team2_ver_position});
      dist1     = diff1[10] ? $unsigned(-diff1) : $unsigned(diff1);
      dist2     = diff2[10] ? $unsigned(-diff2) : $unsigned(diff2);
      hit1      = !dx_pos && (ball_x == X_HIT1) && (dist1 <= PR11);
      hit2      =  dx_pos && (ball_x == X_HIT2) && (dist2 <= PR11);
      goal2     = !dx_pos && !hit1 && (ball_x == X_MIN);
      goal1     =  dx_pos && !hit2 && (ball_x == X_MAX);
      at_bottom = (({1'b0, ball_y} + R11) >= H11);
      at_top    = (ball_y <= Y_MIN);
   end

   // Game FSM: serve delay, ball motion, scoring and end of game.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SERVE;
         serve_cnt   <= '0;
         ball_x      <= INIT_X;
         ball_y      <= INIT_Y;
         dx_pos      <= 1'b1;
         dy_pos      <= 1'b1;
         team1_score <= '0;
         team2_score <= '0;
         goal_pulse  <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         goal_pulse <= 1'b0;
         if (tick) begin
            case (state)
               SERVE: begin
                  if (serve_cnt == SERVE_LAST) begin
                     serve_cnt <= '0;
                     state     <= PLAY;
                  end else begin
                     serve_cnt <= serve_cnt + SERVE_W'(1);
                  end
               end
               PLAY: begin
                  if (goal2) begin
                     team2_score <= team2_score + 4'd1;
                     goal_pulse  <= 1'b1;
                     ball_x      <= INIT_X;
                     ball_y      <= INIT_Y;
                     dy_pos      <= 1'b1;
                     dx_pos      <= 1'b0;
                     if (team2_score == WIN_M1) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                     end else begin
                        state <= SERVE;
                     end
                  end else if (goal1) begin
                     team1_score <= team1_score + 4'd1;
                     goal_pulse  <= 1'b1;
                     ball_x      <= INIT_X;
                     ball_y      <= INIT_Y;
                     dy_pos      <= 1'b1;
                     dx_pos      <= 1'b1;
                     if (team1_score == WIN_M1) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                     end else begin
                        state <= SERVE;
                     end
                  end else begin
                     if (hit1) begin
                        dx_pos <= 1'b1;
                     end else if (hit2) begin
                        dx_pos <= 1'b0;
                     end else if (dx_pos) begin
                        ball_x <= ball_x + 10'd1;
                     end else begin
                        ball_x <= ball_x - 10'd1;
                     end
                     if (dy_pos && at_bottom) begin
                        dy_pos <= 1'b0;
                     end else if (!dy_pos && at_top) begin
                        dy_pos <= 1'b1;
                     end else if (dy_pos) begin
                        ball_y <= ball_y + 10'd1;
                     end else begin
                        ball_y <= ball_y - 10'd1;
                     end
                  end
               end
               OVER: begin
                  game_over <= 1'b1;
               end
               default: begin
                  state <= SERVE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller: checks ball_controller against an integer game model,
// with hand-derived trajectory points plus randomized paddle play.
module tb_ball_controller;

   localparam int FREQ   = 4;
   localparam int SDELAY = 2;
   localparam int WIN    = 2;
   localparam int R      = 8;
   localparam int PR     = 35;
   localparam int T1     = 40;
   localparam int T2     = 600;
   localparam int SW     = 640;
   localparam int SH     = 480;
   localparam int IX     = 320;
   localparam int IY     = 240;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] p1  = 10'd240;
   logic [9:0] p2  = 10'd240;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [3:0] team1_score;
   logic [3:0] team2_score;
   logic       goal_pulse;
   logic       game_over;

   ball_controller #(
      .BALL_MOVEMENT_FREQUENCY(FREQ),
      .SERVE_DELAY(SDELAY),
      .WIN_SCORE(WIN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .team1_ver_position(p1),
      .team2_ver_position(p2),
      .ball_x(ball_x),
      .ball_y(ball_y),
      .team1_score(team1_score),
      .team2_score(team2_score),
      .goal_pulse(goal_pulse),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model of the game, in plain integers
   int mx, my, mvx, mvy, ms1, ms2, mgp, mover, mplay, mserve, mcnt;
   int clk_count = 0;

   // paddle policy: track the ball with an offset, or sit at an absolute row
   int off1 = 0, off2 = 0, absv1 = 0, absv2 = 0;
   bit abs1 = 0, abs2 = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clamp10(input int v);
      if (v < 0) return 0;
      if (v > 1023) return 1023;
      return v;
   endfunction

   function automatic void model_reset();
      mx = IX; my = IY; mvx = 1; mvy = 1;
      ms1 = 0; ms2 = 0; mgp = 0; mover = 0;
      mplay = 0; mserve = SDELAY; mcnt = 0; clk_count = 0;
   endfunction

   function automatic void model_tick(input int q1, input int q2);
      int scored;
      if (mover != 0) return;
      if (mplay == 0) begin
         mserve--;
         if (mserve == 0) begin
            mplay  = 1;
            mserve = SDELAY;
         end
         return;
      end
      scored = 0;
      if (mvx < 0) begin
         if (mx - R == T1 + 1 && iabs(my - q1) <= PR) mvx = 1;
         else if (mx == R) scored = 2;
         else mx--;
      end else begin
         if (mx + R == T2 - 1 && iabs(my - q2) <= PR) mvx = -1;
         else if (mx + R == SW - 1) scored = 1;
         else mx++;
      end
      if (scored != 0) begin
         if (scored == 1) ms1++;
         else ms2++;
         mgp = 1;
         mx  = IX;
         my  = IY;
         mvy = 1;
         mvx = (scored == 1) ? 1 : -1;
         if (ms1 == WIN || ms2 == WIN) mover = 1;
         else begin
            mplay  = 0;
            mserve = SDELAY;
         end
      end else begin
         if (mvy > 0 && my + R >= SH - 1) mvy = -1;
         else if (mvy < 0 && my <= R) mvy = 1;
         else my += mvy;
      end
   endfunction

   // model step, per-cycle compare and paddle drive, all on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            model_reset();
         end else begin
            mgp = 0;
            if (mcnt == FREQ - 1) model_tick(int'(p1), int'(p2));
            mcnt = (mcnt + 1) % FREQ;
            clk_count++;
         end
         check("ball_x", int'(ball_x), mx);
         check("ball_y", int'(ball_y), my);
         check("team1_score", int'(team1_score), ms1);
         check("team2_score", int'(team2_score), ms2);
         check("goal_pulse", int'(goal_pulse), mgp);
         check("game_over", int'(game_over), mover);
         p1 = abs1 ? 10'(absv1) : 10'(clamp10(my + off1));
         p2 = abs2 ? 10'(absv2) : 10'(clamp10(my + off2));
      end
   end

   task automatic goto_tick(input int t);
      int guard = 0;
      while (clk_count < t * FREQ && guard < t * FREQ + 16) begin
         @(negedge clk);
         #2;
         guard++;
      end
      if (clk_count != t * FREQ) check("goto_tick", clk_count, t * FREQ);
   endtask

   task automatic pin(input int t, input int ex, input int ey);
      goto_tick(t);
      check($sformatf("pin_x_t%0d", t), int'(ball_x), ex);
      check($sformatf("pin_y_t%0d", t), int'(ball_y), ey);
      check($sformatf("model_x_t%0d", t), mx, ex);
      check($sformatf("model_y_t%0d", t), my, ey);
   endtask

   task automatic check_all(input string tag, input int ex, input int ey,
                            input int s1, input int s2, input int gp, input int go);
      check({tag, "_x"}, int'(ball_x), ex);
      check({tag, "_y"}, int'(ball_y), ey);
      check({tag, "_s1"}, int'(team1_score), s1);
      check({tag, "_s2"}, int'(team2_score), s2);
      check({tag, "_gp"}, int'(goal_pulse), gp);
      check({tag, "_go"}, int'(game_over), go);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int k;
      int gticks;
      int rticks;
      bit stop;
      off1 = 35; off2 = 0;
      repeat (3) @(negedge clk);
      #1;
      check_all("in_reset", IX, IY, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      check_all("released", IX, IY, 0, 0, 0, 0);

      // serve then first move, bottom wall bounce, team2 paddle return
      pin(2, 320, 240);
      pin(3, 321, 241);
      pin(233, 551, 471);
      pin(234, 552, 471);
      pin(235, 553, 470);
      pin(273, 591, 432);
      pin(274, 591, 431);
      pin(275, 590, 430);
      // team1 paddle at ball_y+35: edge of span still hits
      pin(816, 49, 126);
      pin(817, 49, 127);
      pin(818, 50, 128);
      pin(1360, 591, 273);
      pin(1361, 590, 272);
      // offset 36 misses, ball runs through to the left goal line
      off1 = 36;
      pin(1902, 49, 284);
      pin(1903, 48, 285);
      pin(1943, 8, 325);
      goto_tick(1944);
      check_all("goal1", IX, IY, 0, 1, 1, 0);
      @(negedge clk);
      #2;
      check("goal1_pulse_end", int'(goal_pulse), 0);
      check("goal1_model_pulse_end", mgp, 0);
      off1 = 200;
      pin(1946, 320, 240);
      pin(1947, 319, 241);
      goto_tick(2259);
      check_all("goal2_over", IX, IY, 0, 2, 1, 1);
      goto_tick(2269);
      check_all("over_frozen", IX, IY, 0, 2, 0, 1);
      // asynchronous reset between clock edges
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_all("async_reset", IX, IY, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // randomized paddle play over several games
      rticks = 0;
      while (rticks < 6000) begin
         k = 0;
         gticks = 0;
         stop = 0;
         while (!stop) begin
            off1  = int'($urandom_range(0, 100)) - 50;
            off2  = int'($urandom_range(0, 100)) - 50;
            abs1  = ($urandom_range(0, 7) == 0);
            abs2  = ($urandom_range(0, 7) == 0);
            absv1 = int'($urandom_range(0, 1023));
            absv2 = int'($urandom_range(0, 1023));
            k++;
            goto_tick(k);
            rticks++;
            if (mover != 0) gticks++;
            if (gticks > 3 || k > 3000 || $urandom_range(0, 1499) == 0 || rticks >= 6000)
               stop = 1;
         end
         do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
